// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the program counter and instruction register and
// runs the two-state request/ack handshake to instruction memory, with a timeout.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ir_en_i,
    input  logic               incr_en_i,
    input  logic               pc_load_i,
    input  logic [ADDR_W-1:0]  pc_load_val_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic               imem_req_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               imem_ack_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               fetch_busy_o,
    output logic               fetch_err_o,
    output logic               pc_wrap_o
);

    // state  | meaning
    // S_IDLE | no fetch outstanding, ir_en starts one
    // S_WAIT | imem_req held, waiting for ack or timeout
    typedef enum logic {S_IDLE, S_WAIT} state_e;

    localparam int                 CNT_W    = 8;
    localparam logic [ADDR_W-1:0]  PC_RST   = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  PC_ONES  = '1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] ir_q;
    logic               err_q;
    logic               wrap_q, wrap_d;

    // pc_load wins over incr_en; only a genuine increment from all-ones wraps.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (pc_load_i) begin
            pc_d = pc_load_val_i;
        end else if (incr_en_i) begin
            pc_d   = pc_q + 1'b1;
            wrap_d = (pc_q == PC_ONES);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= PC_RST;
            addr_q  <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
            case (state_q)
                S_IDLE: begin
                    if (ir_en_i) begin
                        addr_q  <= pc_q;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        ir_q    <= imem_rdata_i;
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort with a NOP so the controller never decodes stale data.
                        ir_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_addr_o   = addr_q;
    assign imem_req_o    = (state_q == S_WAIT);
    assign fetch_busy_o  = (state_q == S_WAIT);
    assign instruction_o = ir_q;
    assign pc_o          = pc_q;
    assign fetch_err_o   = err_q;
    assign pc_wrap_o     = wrap_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: handshake latency, ack delay, PC priority/wrap,
// timeout abort, reset mid-fetch and branch during an outstanding fetch.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_en, incr_en, pc_load;
    logic [7:0]  pc_load_val;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [15:0] instruction;
    logic [7:0]  pc;
    logic        fetch_busy, fetch_err, pc_wrap;

    logic        ack_auto, ack_manual;
    logic [15:0] mem [256];

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    assign imem_ack   = ack_auto | ack_manual;

    instr_fetch_unit #(
        .ADDR_W(8), .INSTR_W(16), .RESET_PC(0), .TIMEOUT(15)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ir_en_i       (ir_en),
        .incr_en_i     (incr_en),
        .pc_load_i     (pc_load),
        .pc_load_val_i (pc_load_val),
        .imem_addr_o   (imem_addr),
        .imem_req_o    (imem_req),
        .imem_rdata_i  (imem_rdata),
        .imem_ack_i    (imem_ack),
        .instruction_o (instruction),
        .pc_o          (pc),
        .fetch_busy_o  (fetch_busy),
        .fetch_err_o   (fetch_err),
        .pc_wrap_o     (pc_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
        mem[8'h00] = 16'h0483;
        mem[8'h01] = 16'hA5A5;
        mem[8'h05] = 16'hBEEF;
        mem[8'h20] = 16'h1234;
        mem[8'h40] = 16'h4040;

        rst = 1'b1; ir_en = 0; incr_en = 0; pc_load = 0; pc_load_val = 0;
        ack_auto = 1'b1; ack_manual = 1'b0;
        step(); step();
        check("rst_pc", pc, 8'h00);
        check("rst_instr", instruction, 16'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_busy", fetch_busy, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        check("rst_wrap", pc_wrap, 1'b0);
        rst = 1'b0;

        // 1: ack tied high, fetch + increment together
        ir_en = 1; incr_en = 1;
        step();
        ir_en = 0; incr_en = 0;
        check("t1_req", imem_req, 1'b1);
        check("t1_addr", imem_addr, 8'h00);
        check("t1_pc", pc, 8'h01);
        step();
        check("t1_instr", instruction, 16'h0483);
        check("t1_req_drop", imem_req, 1'b0);
        check("t1_busy_drop", fetch_busy, 1'b0);

        // 2: ack delayed three cycles, ir_en re-pulsed in WAIT
        ack_auto = 0;
        ir_en = 1;
        step();
        ir_en = 0;
        check("t2_req0", imem_req, 1'b1);
        check("t2_addr", imem_addr, 8'h01);
        for (int k = 0; k < 3; k++) begin
            ir_en = (k == 1);
            step();
            check("t2_req_hold", imem_req, 1'b1);
            check("t2_ir_hold", instruction, 16'h0483);
        end
        ir_en = 0; ack_manual = 1;
        step();
        ack_manual = 0;
        check("t2_instr", instruction, 16'hA5A5);
        check("t2_req_drop", imem_req, 1'b0);
        step();
        check("t2_no_queue", fetch_busy, 1'b0);
        check("t2_ir_kept", instruction, 16'hA5A5);

        // 3: wrap and load/increment priority
        pc_load = 1; pc_load_val = 8'hFF;
        step();
        pc_load = 0; incr_en = 1;
        check("t3_pc_ff", pc, 8'hFF);
        step();
        incr_en = 0;
        check("t3_pc_wrap", pc, 8'h00);
        check("t3_wrap_hi", pc_wrap, 1'b1);
        step();
        check("t3_wrap_lo", pc_wrap, 1'b0);
        pc_load = 1; incr_en = 1; pc_load_val = 8'h20;
        step();
        pc_load = 0; incr_en = 0;
        check("t3_load_pri", pc, 8'h20);
        check("t3_no_wrap", pc_wrap, 1'b0);

        // 4: no ack -> timeout after 15 WAIT cycles
        ir_en = 1;
        step();
        ir_en = 0;
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("t4_wait_cycles", n, 15);
        check("t4_instr_nop", instruction, 16'h0);
        check("t4_err", fetch_err, 1'b1);
        check("t4_busy", fetch_busy, 1'b0);
        ack_auto = 1; ir_en = 1;
        step();
        ir_en = 0;
        step();
        check("t4_err_clr", fetch_err, 1'b0);
        check("t4_instr", instruction, 16'h1234);

        // 5: reset in the middle of a fetch
        ack_auto = 0; ir_en = 1; incr_en = 1;
        step();
        ir_en = 0; incr_en = 0;
        step();
        check("t5_busy_pre", fetch_busy, 1'b1);
        rst = 1;
        #1;
        check("t5_req", imem_req, 1'b0);
        check("t5_busy", fetch_busy, 1'b0);
        check("t5_pc", pc, 8'h00);
        check("t5_instr", instruction, 16'h0);
        step();
        rst = 0; ack_manual = 1;
        step();
        ack_manual = 0;
        check("t5_late_ack", instruction, 16'h0);
        check("t5_idle", fetch_busy, 1'b0);

        // 6: branch while a fetch to 0x05 is outstanding
        pc_load = 1; pc_load_val = 8'h05;
        step();
        pc_load = 0; ir_en = 1;
        step();
        ir_en = 0;
        check("t6_addr", imem_addr, 8'h05);
        pc_load = 1; pc_load_val = 8'h40;
        step();
        pc_load = 0;
        check("t6_pc", pc, 8'h40);
        check("t6_addr_kept", imem_addr, 8'h05);
        ack_manual = 1;
        step();
        ack_manual = 0;
        check("t6_instr", instruction, 16'hBEEF);
        ack_auto = 1; ir_en = 1;
        step();
        ir_en = 0;
        check("t6_next_addr", imem_addr, 8'h40);
        step();
        check("t6_next_instr", instruction, 16'h4040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
